// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus for the fetch stage.
// Master drives req/addr; slave returns ready/rdata.
interface fetch_stage_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 32
);
   logic               req;
   logic [PC_W-1:0]    addr;
   logic               ready;
   logic [INSTR_W-1:0] rdata;

   modport master (
      output req,
      output addr,
      input  ready,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ready,
      output rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Fetch front end: PC, imem handshake, one-entry hold, redirect drain.
// Optional watchdog built only with FETCH_TIMEOUT_EN.
module fetch_stage #(
   parameter int PC_W     = 8,
   parameter int INSTR_W  = 32,
   parameter int PC_INC   = 1,
   parameter int RESET_PC = 0
`ifdef FETCH_TIMEOUT_EN
   , parameter int TIMEOUT = 16
`endif
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    redirect,
   input  logic [PC_W-1:0]         redirect_pc,
   fetch_stage_if.master           imem,
   output logic [PC_W+INSTR_W:0]   fetch_out,
   output logic                    ifid_w_en
`ifdef FETCH_TIMEOUT_EN
   , output logic                  fetch_timeout
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD,
      DRAIN
   } state_t;

   localparam logic [PC_W-1:0] INC  = PC_W'(PC_INC);
   localparam logic [PC_W-1:0] RPC  = PC_W'(RESET_PC);
   localparam logic [INSTR_W-1:0] NOP = {INSTR_W{1'b0}};

   state_t                  state, state_nx;
   logic [PC_W-1:0]         pc, pc_nx;
   logic [PC_W-1:0]         drain_addr, drain_nx;
   logic [PC_W-1:0]         hold_pc, hold_pc_nx;
   logic [INSTR_W-1:0]      hold_instr, hold_instr_nx;
   logic [PC_W+INSTR_W:0]   fo_nx;

   assign ifid_w_en = reset & (~stall | redirect);

   // State, PC, hold entry and output packet registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         pc         <= RPC;
         drain_addr <= RPC;
         hold_pc    <= RPC;
         hold_instr <= NOP;
         fetch_out  <= '0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         drain_addr <= drain_nx;
         hold_pc    <= hold_pc_nx;
         hold_instr <= hold_instr_nx;
         fetch_out  <= fo_nx;
      end
   end

   // Next-state, request and packet logic; redirect overrides all.
   always_comb begin
      state_nx      = state;
      pc_nx         = pc;
      drain_nx      = drain_addr;
      hold_pc_nx    = hold_pc;
      hold_instr_nx = hold_instr;
      fo_nx         = fetch_out;
      imem.req      = 1'b0;
      imem.addr     = pc;
      unique case (state)
         IDLE: state_nx = REQ;
         REQ: begin
            imem.req = 1'b1;
            if (imem.ready && !stall) begin
               fo_nx = {1'b1, pc, imem.rdata};
               pc_nx = pc + INC;
            end else if (imem.ready) begin
               hold_pc_nx    = pc;
               hold_instr_nx = imem.rdata;
               state_nx      = HOLD;
            end else if (!stall) begin
               fo_nx = {1'b0, pc, NOP};
            end
         end
         HOLD: begin
            if (!stall) begin
               fo_nx    = {1'b1, hold_pc, hold_instr};
               pc_nx    = pc + INC;
               state_nx = REQ;
            end
         end
         DRAIN: begin
            imem.req  = 1'b1;
            imem.addr = drain_addr;
            if (imem.ready) state_nx = REQ;
         end
         default: state_nx = IDLE;
      endcase
      if (redirect) begin
         pc_nx = redirect_pc;
         fo_nx = {1'b0, redirect_pc, NOP};
         unique case (state)
            REQ: begin
               if (!imem.ready) begin
                  state_nx = DRAIN;
                  drain_nx = pc;
               end else begin
                  state_nx = REQ;
               end
            end
            DRAIN:   state_nx = DRAIN;
            default: state_nx = REQ;
         endcase
      end
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);
   localparam logic [CW-1:0] TPRE = CW'(TIMEOUT - 1);

   logic [CW-1:0] to_cnt;

   // Wait-cycle counter with sticky timeout flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt        <= '0;
         fetch_timeout <= 1'b0;
      end else begin
         if (redirect || imem.ready) begin
            to_cnt <= '0;
         end else if (imem.req && to_cnt != TLIM) begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (imem.req && !imem.ready && !redirect &&
             to_cnt == TPRE) begin
            fetch_timeout <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed plan plus random traffic.
// Expected packets follow from the PC stream and redirect targets.
module tb_fetch_stage;
   localparam int PW = 8;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          stall;
   logic          redirect;
   logic [PW-1:0] redirect_pc;
   logic [PW+IW:0] fetch_out;
   logic          ifid_w_en;
`ifdef FETCH_TIMEOUT_EN
   logic          fetch_timeout;
`endif

   fetch_stage_if #(.PC_W(PW), .INSTR_W(IW)) imem ();

   fetch_stage dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .imem(imem),
      .fetch_out(fetch_out),
      .ifid_w_en(ifid_w_en)
`ifdef FETCH_TIMEOUT_EN
      , .fetch_timeout(fetch_timeout)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int npkt = 0;
   logic [PW+IW-1:0] sb[$];
   logic [PW-1:0]    nxt;

   function automatic logic [IW-1:0] memf(input logic [PW-1:0] a);
      return 32'h0000_00A0 + {24'h0, a};
   endfunction

   // Zero-wait memory model; junk data when not ready.
   always_comb begin
      if (imem.ready) imem.rdata = memf(imem.addr);
      else imem.rdata = 32'hBAD0_0000 | {24'h0, imem.addr};
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic refill();
      while (sb.size() < 8) begin
         sb.push_back({nxt, memf(nxt)});
         nxt = nxt + 8'd1;
      end
   endtask

   task automatic step(input logic s, input logic r,
                       input logic [PW-1:0] rp,
                       input logic rdy);
      stall = s;
      redirect = r;
      redirect_pc = rp;
      imem.ready = rdy;
      if (r) begin
         sb.delete();
         nxt = rp;
      end
      refill();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_fo", 64'(fetch_out), 64'h0);
      chk("rst_req", 64'(imem.req), 64'h0);
      chk("rst_wen", 64'(ifid_w_en), 64'h0);
      sb.delete();
      nxt = 8'h00;
      @(negedge clk);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("rst_hold_fo", 64'(fetch_out), 64'h0);
      reset = 1'b1;
   endtask

   // Monitor: pops the scoreboard on every freshly written valid packet.
   always begin
      logic s, r, rs, rq, rd;
      logic [PW-1:0] rp, ad;
      logic [PW+IW:0] pre;
      logic [PW+IW-1:0] e;
      @(posedge clk);
      s = stall; r = redirect; rp = redirect_pc; rs = reset;
      rq = imem.req; rd = imem.ready; ad = imem.addr;
      pre = fetch_out;
      chk("wen", 64'(ifid_w_en), 64'(rs & (~s | r)));
      #1;
      if (rs && reset) begin
         if (r) begin
            chk("redir_fo", 64'(fetch_out),
                64'({1'b0, rp, 32'h0}));
         end else if (s) begin
            chk("stall_fo", 64'(fetch_out), 64'(pre));
         end else if (fetch_out[PW+IW]) begin
            npkt++;
            if (sb.size() == 0) begin
               chk("sb_empty", 64'(fetch_out), 64'h0);
            end else begin
               e = sb.pop_front();
               chk("pkt", 64'(fetch_out[PW+IW-1:0]), 64'(e));
            end
         end
         if (rq && !rd && imem.req) begin
            chk("addr_stable", 64'(imem.addr), 64'(ad));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int base;
      reset = 1'b0;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      imem.ready = 1'b0;
      repeat (3) @(negedge clk);
      do_reset();

      step(1'b0, 1'b0, 8'h00, 1'b1);
      repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("seq_npkt", 64'(npkt), 64'd5);
      repeat (3) begin
         step(1'b1, 1'b0, 8'h00, 1'b1);
         chk("hold_req", 64'(imem.req), 64'h0);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("hold_out", 64'(fetch_out),
          64'({1'b1, 8'h05, 32'hA5}));
      chk("after_hold_addr", 64'(imem.addr), 64'h06);
      chk("after_hold_req", 64'(imem.req), 64'h1);

      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("wait_addr", 64'(imem.addr), 64'h07);
      step(1'b0, 1'b1, 8'h40, 1'b0);
      chk("drain_addr", 64'(imem.addr), 64'h07);
      chk("drain_req", 64'(imem.req), 64'h1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("drain_addr2", 64'(imem.addr), 64'h07);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain_done_addr", 64'(imem.addr), 64'h40);
      chk("drain_done_v", 64'(fetch_out[PW+IW]), 64'h0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("first_40", 64'(fetch_out),
          64'({1'b1, 8'h40, 32'hE0}));

      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 8'h40;
      #1;
      chk("redir_stall_wen", 64'(ifid_w_en), 64'h1);
      step(1'b1, 1'b1, 8'h40, 1'b1);
      chk("redir_ready_fo", 64'(fetch_out),
          64'({1'b0, 8'h40, 32'h0}));

      step(1'b0, 1'b1, 8'hFD, 1'b1);
      repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("wrap_addr", 64'(imem.addr), 64'h00);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("wrap_pkt", 64'(fetch_out),
          64'({1'b1, 8'h00, 32'hA0}));

      base = npkt;
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 3,
              $urandom_range(0, 9) == 0,
              PW'($urandom),
              $urandom_range(0, 9) < 6);
      end
      chk("rand_progress", 64'(npkt - base > 30), 64'h1);

      step(1'b0, 1'b0, 8'h00, 1'b0);
      do_reset();
      base = npkt;
      step(1'b0, 1'b0, 8'h00, 1'b1);
      repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("post_rst_npkt", 64'(npkt - base), 64'd3);

`ifdef FETCH_TIMEOUT_EN
      do_reset();
      step(1'b0, 1'b0, 8'h00, 1'b0);
      repeat (15) step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("to_early", 64'(fetch_timeout), 64'h0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("to_set", 64'(fetch_timeout), 64'h1);
      step(1'b0, 1'b1, 8'h10, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("to_sticky", 64'(fetch_timeout), 64'h1);
      reset = 1'b0;
      #1;
      chk("to_rst", 64'(fetch_timeout), 64'h0);
      reset = 1'b1;
`endif

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule
